jt12_kon: RTL and testbench

- Key-on/key-off sequencer for the JT12 FM core. It sits between the register interface and the envelope generator.
- Accepts CPU writes to YM2612 register 0x28 and keeps the key state of all 24 operator slots.
- Emits single-cycle, per-slot keyon/keyoff pulses aligned with the time-multiplexed slot sequence the envelope generator consumes at its stage II.

---
 rtl/jt12_kon.sv | 119 +++++++++++
 tb/tb_jt12_kon.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/jt12_kon.sv
// jt12_kon: YM2612 reg 0x28 key sequencer emitting per-slot keyon/keyoff pulses; JT12_KON_CSM_EN adds CSM key pulses on ch2
module jt12_kon #(
  parameter int NUM_CH = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       zero,
  input  logic [7:0] din,
  input  logic       kon_we,
`ifdef JT12_KON_CSM_EN
  input  logic       csm_en,
  input  logic       tima_ovf,
`endif
  output logic       keyon_II,
  output logic       keyoff_II,
  output logic [4:0] slot_II,
  output logic       busy,
  output logic [3:0] kon_ch2
);
  localparam logic [4:0] LAST = 5'(4 * NUM_CH - 1);
  logic [4:0]  r_cnt;
  logic [23:0] r_kst;
  logic        r_pend;
  logic [2:0]  r_pend_ch;
  logic [3:0]  r_pend_keys;
  logic [4:0]  r_rem;
  logic [1:0]  w_op;
  logic [1:0]  w_kbit;
  logic [2:0]  w_ch;
  logic [2:0]  w_wch;
  logic        w_wvalid;
  logic        w_hit;
  logic        w_new;
  logic        w_old;
  logic        w_kon;
  logic        w_koff;
  logic        w_unused;
  assign w_op     = r_cnt >= 5'(3 * NUM_CH) ? 2'd3 :
                    r_cnt >= 5'(2 * NUM_CH) ? 2'd2 :
                    r_cnt >= 5'(NUM_CH)     ? 2'd1 : 2'd0;
  assign w_ch     = 3'(r_cnt - 5'(w_op) * 5'(NUM_CH));
  // rotation order S1,S3,S2,S4 is the bit-reverse of the din key position
  assign w_kbit   = {w_op[0], w_op[1]};
  assign w_old    = r_kst[r_cnt];
  assign w_new    = r_pend_keys[w_kbit];
  assign w_hit    = r_pend && w_ch == r_pend_ch;
  assign w_wvalid = kon_we && din[1:0] != 2'd3;
  assign w_wch    = din[2] ? 3'(din[1:0]) + 3'd3 : 3'(din[1:0]);
  assign w_unused = din[3];
  assign busy     = r_pend;
  assign kon_ch2  = {r_kst[20], r_kst[8], r_kst[14], r_kst[2]};
`ifdef JT12_KON_CSM_EN
  typedef enum logic [1:0] {CSM_IDLE, CSM_ARM, CSM_ON, CSM_OFF} csm_t;
  csm_t       r_csm_st;
  csm_t       w_csm_nx;
  logic [3:0] r_csm_mask;
  logic       w_csm_slot;
  logic       w_csm_kon;
  logic       w_csm_koff;
  assign w_csm_slot = !w_hit && w_ch == 3'd2;
  assign w_csm_kon  = w_csm_slot && r_csm_st == CSM_ON && !w_old;
  assign w_csm_koff = w_csm_slot && r_csm_st == CSM_OFF && r_csm_mask[w_kbit] && !w_old;
  always_comb begin
    w_csm_nx = r_csm_st;
    if (r_cnt == LAST)
      w_csm_nx = r_csm_st == CSM_ARM ? CSM_ON : r_csm_st == CSM_ON ? CSM_OFF : CSM_IDLE;
    if (tima_ovf && csm_en)
      w_csm_nx = CSM_ARM;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_csm_st   <= CSM_IDLE;
      r_csm_mask <= 4'd0;
    end else begin
      r_csm_st <= w_csm_nx;
      if (r_csm_st == CSM_ARM)
        r_csm_mask <= 4'd0;
      if (r_csm_st == CSM_ON && w_ch == 3'd2)
        r_csm_mask[w_kbit] <= w_csm_kon;
    end
  end
  assign w_kon  = (w_hit && w_new && !w_old) || w_csm_kon;
  assign w_koff = (w_hit && !w_new && w_old) || w_csm_koff;
`else
  assign w_kon  = w_hit && w_new && !w_old;
  assign w_koff = w_hit && !w_new && w_old;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt       <= 5'd0;
      r_kst       <= 24'd0;
      r_pend      <= 1'b0;
      r_pend_ch   <= 3'd0;
      r_pend_keys <= 4'd0;
      r_rem       <= 5'd0;
      keyon_II    <= 1'b0;
      keyoff_II   <= 1'b0;
      slot_II     <= 5'd0;
    end else begin
      r_cnt     <= zero || r_cnt == LAST ? 5'd0 : r_cnt + 5'd1;
      slot_II   <= r_cnt;
      keyon_II  <= w_kon;
      keyoff_II <= w_koff;
      if (w_hit)
        r_kst[r_cnt] <= w_new;
      if (r_pend) begin
        r_rem <= r_rem - 5'd1;
        if (r_rem == 5'd1)
          r_pend <= 1'b0;
      end
      if (w_wvalid) begin
        r_pend      <= 1'b1;
        r_pend_ch   <= w_wch;
        r_pend_keys <= din[7:4];
        r_rem       <= 5'd24;
      end
    end
  end
endmodule

// File: tb/tb_jt12_kon.sv
// tb_jt12_kon: directed 0x28 writes checked against a window-based key model plus literal pulse masks
module tb_jt12_kon;
  logic       clk = 0, rst = 1, zero = 0, kon_we = 0;
  logic [7:0] din = 0;
  logic       keyon_II, keyoff_II, busy;
  logic [4:0] slot_II;
  logic [3:0] kon_ch2;

  jt12_kon dut (
    .clk(clk), .rst(rst), .zero(zero), .din(din), .kon_we(kon_we),
    .keyon_II(keyon_II), .keyoff_II(keyoff_II), .slot_II(slot_II),
    .busy(busy), .kon_ch2(kon_ch2)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Model: a write at edge wc owns the 24 following edges; any edge in that window
  // landing on a slot of the target channel loads the written key bit into that slot.
  bit         mk[24];
  int         mcnt, cyc, wc, wend, mch;
  logic [3:0] mkeys;
  bit         e_on, e_off, e_busy, nk;
  int         e_slot;
  int         opbit[4] = '{0, 2, 1, 3};

  always @(posedge clk) begin
    if (rst) begin
      mk = '{default: 0};
      mcnt = 0; cyc = 0; wc = -100; wend = -100;
      e_on = 0; e_off = 0; e_slot = 0; e_busy = 0;
    end else begin
      e_on = 0; e_off = 0; e_slot = mcnt;
      if (cyc > wc && cyc <= wend && mcnt % 6 == mch) begin
        nk = mkeys[opbit[mcnt / 6]];
        e_on = nk && !mk[mcnt];
        e_off = !nk && mk[mcnt];
        mk[mcnt] = nk;
      end
      if (kon_we && din[1:0] != 2'd3) begin
        wc = cyc; wend = cyc + 24;
        mch = din[2] ? int'(din[1:0]) + 3 : int'(din[1:0]);
        mkeys = din[7:4];
      end
      e_busy = (cyc + 1 > wc) && (cyc + 1 <= wend);
      mcnt = zero ? 0 : (mcnt + 1) % 24;
      cyc++;
    end
  end

  bit          chk_en = 0;
  logic [23:0] on_mask, off_mask;
  int          on_n, off_n, busy_n;

  always @(negedge clk) begin
    if (chk_en) begin
      chk("keyon", keyon_II, e_on);
      chk("keyoff", keyoff_II, e_off);
      chk("slot", slot_II, e_slot);
      chk("busy", busy, e_busy);
      chk("kon_ch2", kon_ch2, {mk[20], mk[8], mk[14], mk[2]});
      chk("excl", keyon_II & keyoff_II, 0);
      if (keyon_II === 1'b1) begin on_mask |= 24'(1) << slot_II; on_n++; end
      if (keyoff_II === 1'b1) begin off_mask |= 24'(1) << slot_II; off_n++; end
      if (busy === 1'b1) busy_n++;
    end
  end

  int ph = 0;

  task automatic tick(input bit we = 0, input logic [7:0] d = 8'h00, input bit r = 0);
    rst = r; kon_we = we; din = d; zero = (ph == 23);
    @(posedge clk); #1;
    ph = (r || ph == 23) ? 0 : ph + 1;
    rst = 0; kon_we = 0;
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic clear();
    on_mask = 0; off_mask = 0; on_n = 0; off_n = 0; busy_n = 0;
  endtask

  initial begin
    clear();
    tick(0, 8'h00, 1);
    tick(0, 8'h00, 1);
    chk_en = 1;
    chk("rst_slot", slot_II, 0);
    chk("rst_busy", busy, 0);
    chk("rst_keyon", keyon_II, 0);
    run(48);
    chk("idle_on_n", on_n, 0);
    chk("idle_off_n", off_n, 0);

    clear(); tick(1, 8'hF1); run(30);
    chk("f1_on_mask", on_mask, 24'h082082);
    chk("f1_on_n", on_n, 4);
    chk("f1_off_n", off_n, 0);
    chk("f1_busy_n", busy_n, 24);

    clear(); tick(1, 8'h51); run(30);
    chk("51_off_mask", off_mask, 24'h082000);
    chk("51_off_n", off_n, 2);
    chk("51_on_n", on_n, 0);

    clear(); tick(1, 8'hF3);
    chk("f3_busy", busy, 0);
    tick(1, 8'hF7);
    chk("f7_busy", busy, 0);
    run(30);
    chk("f37_pulses", on_n + off_n, 0);
    chk("f37_busy_n", busy_n, 0);
    chk("f37_ch2", kon_ch2, 4'h0);

    clear(); tick(1, 8'hF6); run(30);
    chk("f6_on_mask", on_mask, 24'h820820);
    chk("f6_on_n", on_n, 4);

    clear(); tick(1, 8'hF2);
    chk("f2_busy", busy, 1);
    run(4);
    tick(1, 8'h02); run(30);
    chk("02_ch2", kon_ch2, 4'h0);
    chk("02_pairs", off_mask, on_mask);
    chk("02_pair_n", off_n, on_n);

    tick(1, 8'hF2); run(30);
    chk("f2_ch2", kon_ch2, 4'hF);
    tick(1, 8'hF0); run(3);
    tick(0, 8'h00, 1);
    chk("mrst_keyon", keyon_II, 0);
    chk("mrst_keyoff", keyoff_II, 0);
    chk("mrst_slot", slot_II, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_ch2", kon_ch2, 4'h0);
    clear(); tick(1, 8'h10); run(30);
    chk("10_on_mask", on_mask, 24'h000001);
    chk("10_on_n", on_n, 1);
    chk("10_off_n", off_n, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
